// File: rtl/gray_counter_ud_if.sv
// Control and count bus of the up/down Gray counter.
// The master drives the step and load requests; the slave returns the registered count.
interface gray_counter_ud_if #(
    parameter int unsigned N = 8
);
    logic         en;
    logic         up;
    logic         load;
    logic [N-1:0] load_gray;
    logic [N-1:0] gray_code;
    logic [N-1:0] bin_code;
    logic         tc;

    modport master (
        output en, up, load, load_gray,
        input  gray_code, bin_code, tc
    );

    modport slave (
        input  en, up, load, load_gray,
        output gray_code, bin_code, tc
    );
endinterface

// File: rtl/gray_counter_ud.sv
// N-bit up/down Gray-code counter with Gray load, wrap or saturate mode and terminal-count pulse.
// The count is held in binary; the Gray and binary views are registered together.
module gray_counter_ud #(
    parameter int unsigned N    = 8,
    parameter int unsigned WRAP = 1,
    parameter int unsigned INIT = 0
) (
    input  logic              clk,
    input  logic              rst,
    gray_counter_ud_if.slave  bus
);
    localparam logic [N-1:0] BIN_MAX   = {N{1'b1}};
    localparam logic [N-1:0] BIN_ONE   = N'(1);
    localparam logic [N-1:0] INIT_BIN  = N'(INIT);
    localparam logic [N-1:0] INIT_GRAY = INIT_BIN ^ (INIT_BIN >> 1);
    localparam bit           WRAP_EN   = (WRAP != 0);

    logic [N-1:0] r_bin;
    logic [N-1:0] r_gray;
    logic         r_tc;
    logic [N-1:0] w_bin_nxt;
    logic [N-1:0] w_gray_nxt;
    logic         w_tc_nxt;

    function automatic logic [N-1:0] gray2bin(input logic [N-1:0] g);
        logic [N-1:0] b;
        b[N-1] = g[N-1];
        for (int i = int'(N) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Next count: load beats enable; limits either wrap with tc or saturate.
    always_comb begin
        w_bin_nxt = r_bin;
        w_tc_nxt  = 1'b0;
        if (bus.load) begin
            w_bin_nxt = gray2bin(bus.load_gray);
        end else if (bus.en) begin
            if (bus.up) begin
                if (r_bin != BIN_MAX) begin
                    w_bin_nxt = r_bin + BIN_ONE;
                    w_tc_nxt  = !WRAP_EN && (r_bin == (BIN_MAX - BIN_ONE));
                end else if (WRAP_EN) begin
                    w_bin_nxt = '0;
                    w_tc_nxt  = 1'b1;
                end
            end else begin
                if (r_bin != '0) begin
                    w_bin_nxt = r_bin - BIN_ONE;
                    w_tc_nxt  = !WRAP_EN && (r_bin == BIN_ONE);
                end else if (WRAP_EN) begin
                    w_bin_nxt = BIN_MAX;
                    w_tc_nxt  = 1'b1;
                end
            end
        end
    end

    assign w_gray_nxt = w_bin_nxt ^ (w_bin_nxt >> 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin  <= INIT_BIN;
            r_gray <= INIT_GRAY;
            r_tc   <= 1'b0;
        end else begin
            r_bin  <= w_bin_nxt;
            r_gray <= w_gray_nxt;
            r_tc   <= w_tc_nxt;
        end
    end

    assign bus.bin_code  = r_bin;
    assign bus.gray_code = r_gray;
    assign bus.tc        = r_tc;
endmodule

// File: tb/tb_gray_counter_ud.sv
// Scoreboard bench for gray_counter_ud: four instances cover wrap, saturate, non-zero INIT and an N=8 random sweep.
module tb_gray_counter_ud;
    localparam int unsigned NDUT = 4;

    typedef struct {
        int          sel;
        int unsigned bin;
        bit          tc;
        bit          step;
        int unsigned prev_gray;
    } exp_t;

    logic            clk = 1'b0;
    logic [NDUT-1:0] rst_v;

    int unsigned cfg_n    [NDUT] = '{4, 4, 4, 8};
    bit          cfg_wrap [NDUT] = '{1'b1, 1'b0, 1'b1, 1'b1};
    int unsigned cfg_init [NDUT] = '{0, 0, 5, 0};
    int unsigned m_bin    [NDUT];

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned last_bin, last_gray, last_tc;

    always #5 clk = ~clk;

    gray_counter_ud_if #(.N(4)) if0 ();
    gray_counter_ud_if #(.N(4)) if1 ();
    gray_counter_ud_if #(.N(4)) if2 ();
    gray_counter_ud_if #(.N(8)) if3 ();

    gray_counter_ud #(.N(4), .WRAP(1), .INIT(0)) u_wrap (.clk(clk), .rst(rst_v[0]), .bus(if0.slave));
    gray_counter_ud #(.N(4), .WRAP(0), .INIT(0)) u_sat  (.clk(clk), .rst(rst_v[1]), .bus(if1.slave));
    gray_counter_ud #(.N(4), .WRAP(1), .INIT(5)) u_init (.clk(clk), .rst(rst_v[2]), .bus(if2.slave));
    gray_counter_ud #(.N(8), .WRAP(1), .INIT(0)) u_rand (.clk(clk), .rst(rst_v[3]), .bus(if3.slave));

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Gray to binary by prefix XOR over the higher bits.
    function automatic int unsigned g2b(input int unsigned g, input int unsigned n);
        int unsigned b = g;
        for (int s = 1; s < int'(n); s = s * 2) b ^= (b >> s);
        return b & ((32'd1 << n) - 32'd1);
    endfunction

    task automatic idle_all();
        if0.en = 0; if0.up = 0; if0.load = 0; if0.load_gray = '0;
        if1.en = 0; if1.up = 0; if1.load = 0; if1.load_gray = '0;
        if2.en = 0; if2.up = 0; if2.load = 0; if2.load_gray = '0;
        if3.en = 0; if3.up = 0; if3.load = 0; if3.load_gray = '0;
    endtask

    task automatic compare_out();
        exp_t        e;
        int unsigned gb, gg, gt;
        e = sb.pop_front();
        case (e.sel)
            0:       begin gb = if0.bin_code; gg = if0.gray_code; gt = if0.tc; end
            1:       begin gb = if1.bin_code; gg = if1.gray_code; gt = if1.tc; end
            2:       begin gb = if2.bin_code; gg = if2.gray_code; gt = if2.tc; end
            default: begin gb = if3.bin_code; gg = if3.gray_code; gt = if3.tc; end
        endcase
        check_eq($sformatf("bin dut%0d", e.sel), gb, e.bin);
        check_eq($sformatf("gray dut%0d", e.sel), gg, e.bin ^ (e.bin >> 1));
        check_eq($sformatf("tc dut%0d", e.sel), gt, 32'(e.tc));
        if (e.step)
            check_eq($sformatf("onebit dut%0d", e.sel), 32'($countones(gg ^ e.prev_gray)), 1);
        last_bin = gb; last_gray = gg; last_tc = gt;
    endtask

    // One clock on instance sel: model computes the expectation, DUT is driven, result compared after the edge.
    task automatic cycle(input int sel, input bit r, input bit ld, input bit e, input bit u,
                         input int unsigned lg);
        int unsigned mx, cur, nxt;
        bit          t;
        exp_t        x;
        mx  = (32'd1 << cfg_n[sel]) - 32'd1;
        cur = m_bin[sel];
        nxt = cur;
        t   = 1'b0;
        if (r) nxt = cfg_init[sel];
        else if (ld) nxt = g2b(lg & mx, cfg_n[sel]);
        else if (e) begin
            if (u) begin
                if (cur != mx) begin nxt = cur + 1; t = !cfg_wrap[sel] && (nxt == mx); end
                else if (cfg_wrap[sel]) begin nxt = 0; t = 1'b1; end
            end else begin
                if (cur != 0) begin nxt = cur - 1; t = !cfg_wrap[sel] && (nxt == 0); end
                else if (cfg_wrap[sel]) begin nxt = mx; t = 1'b1; end
            end
        end
        x.sel = sel; x.bin = nxt; x.tc = t;
        x.step = !r && !ld && e && (nxt != cur);
        x.prev_gray = cur ^ (cur >> 1);
        sb.push_back(x);
        m_bin[sel] = nxt;

        idle_all();
        rst_v = '0;
        rst_v[sel] = r;
        case (sel)
            0:       begin if0.en = e; if0.up = u; if0.load = ld; if0.load_gray = 4'(lg); end
            1:       begin if1.en = e; if1.up = u; if1.load = ld; if1.load_gray = 4'(lg); end
            2:       begin if2.en = e; if2.up = u; if2.load = ld; if2.load_gray = 4'(lg); end
            default: begin if3.en = e; if3.up = u; if3.load = ld; if3.load_gray = 8'(lg); end
        endcase
        @(posedge clk);
        #1;
        compare_out();
    endtask

    initial begin
        int unsigned seq[17] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                                 4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
        idle_all();
        rst_v = '1;
        @(posedge clk);
        #1;
        for (int i = 0; i < int'(NDUT); i++) m_bin[i] = cfg_init[i];

        // Reset values of every instance
        for (int i = 0; i < int'(NDUT); i++) cycle(i, 1, 0, 0, 0, 0);
        check_eq("t1_seq0", if0.gray_code, seq[0]);

        // Up count with wrap on N=4
        for (int i = 1; i <= 16; i++) begin
            cycle(0, 0, 0, 1, 1, 0);
            check_eq($sformatf("t1_seq%0d", i), last_gray, seq[i]);
            check_eq($sformatf("t1_tc%0d", i), last_tc, (i == 16) ? 1 : 0);
        end

        // Down wrap from 0
        cycle(0, 0, 0, 1, 0, 0);
        check_eq("t2_bin", last_bin, 4'b1111);
        check_eq("t2_gray", last_gray, 4'b1000);
        check_eq("t2_tc", last_tc, 1);
        cycle(0, 0, 0, 1, 0, 0);
        check_eq("t2_bin2", last_bin, 4'b1110);
        check_eq("t2_gray2", last_gray, 4'b1001);

        // Load wins over enable, then one up step
        cycle(0, 0, 1, 1, 1, 4'b1010);
        check_eq("t3_bin", last_bin, 4'b1100);
        check_eq("t3_tc", last_tc, 0);
        cycle(0, 0, 0, 1, 1, 0);
        check_eq("t3_gray", last_gray, 4'b1011);

        // Saturate mode
        cycle(1, 0, 1, 0, 0, 4'b1001);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 0, 1, 1, 0);
            check_eq("t4_up_bin", last_bin, 15);
            check_eq("t4_up_tc", last_tc, (i == 0) ? 1 : 0);
        end
        for (int i = 0; i < 15; i++) cycle(1, 0, 0, 1, 0, 0);
        check_eq("t4_dn_bin", last_bin, 0);
        check_eq("t4_dn_tc", last_tc, 1);
        for (int i = 0; i < 2; i++) cycle(1, 0, 0, 1, 0, 0);
        check_eq("t4_hold_tc", last_tc, 0);
        cycle(1, 0, 1, 1, 1, 4'b1000);
        check_eq("t4_loadmax_tc", last_tc, 0);
        cycle(1, 0, 0, 1, 0, 0);

        // Reset priority on INIT=5 instance, then enable toggling
        for (int i = 0; i < 4; i++) cycle(2, 0, 0, 1, 1, 0);
        check_eq("t5_pre", last_bin, 9);
        cycle(2, 1, 1, 1, 1, 4'b0011);
        check_eq("t5_bin", last_bin, 4'b0101);
        check_eq("t5_gray", last_gray, 4'b0111);
        cycle(2, 0, 0, 1, 1, 0);
        cycle(2, 0, 0, 0, 1, 0);
        check_eq("t5_hold", last_bin, 6);
        cycle(2, 0, 0, 1, 0, 0);
        cycle(2, 0, 0, 1, 0, 0);

        // Random sweep on N=8
        for (int i = 0; i < 10000; i++) begin
            cycle(3, ($urandom_range(0, 499) == 0), ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), $urandom_range(0, 255));
        end

        check_eq("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
